// File: rtl/hit_detector.sv
// hit_detector: flags overlap between the player box and obstacle-coloured
// pixels. It emits one hit pulse at frame end, then holds an invulnerability
// window counted in frames. The video stream is passed through with 1-cycle latency.
module hit_detector #(
    parameter int          PLAYER_SIZE    = 20,
    parameter logic [11:0] OBSTACLE_COLOR = 12'hf_0_0,
    parameter int          INVULN_FRAMES  = 60,
    parameter int          HIT_CNT_W      = 3
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [11:0]          hcount_in,
    input  logic [11:0]          vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [11:0]          rgb_in,
    input  logic [11:0]          player_x,
    input  logic [11:0]          player_y,
    input  logic                 game_on,
    output logic [11:0]          hcount_out,
    output logic [11:0]          vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [11:0]          rgb_out,
    output logic                 player_hit,
    output logic                 invuln,
    output logic [HIT_CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN} state_t;

    localparam logic [7:0]           INV_LD  = 8'(INVULN_FRAMES);
    localparam logic [HIT_CNT_W-1:0] CNT_MAX = '1;

    state_t               state_q;
    logic                 flag_q;
    logic [7:0]           frm_cnt_q;
    logic                 vblnk_prev_q;
    logic                 hit_q;
    logic                 invuln_q;
    logic [HIT_CNT_W-1:0] hit_cnt_q;

    // The box edges are 13 bits wide, so a box at the right or bottom border does not wrap to 0.
    logic [12:0] px_end, py_end;
    logic        in_box, frame_end, sample;

    // In-box test, frame-end edge detect and collision sample on the current inputs.
    always_comb begin
        px_end    = {1'b0, player_x} + 13'(PLAYER_SIZE);
        py_end    = {1'b0, player_y} + 13'(PLAYER_SIZE);
        in_box    = (hcount_in >= player_x) && ({1'b0, hcount_in} < px_end) &&
                    (vcount_in >= player_y) && ({1'b0, vcount_in} < py_end);
        frame_end = vblnk_in & ~vblnk_prev_q;
        sample    = (state_q == ARMED) & ~vblnk_in & ~hblnk_in & in_box &
                    (rgb_in == OBSTACLE_COLOR);
    end

    // Video pass-through, one register stage; colours are never altered.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_in;
        end
    end

    // Hit FSM: sticky collision flag resolved at frame end, then a frame-counted cooldown.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            flag_q       <= 1'b0;
            frm_cnt_q    <= '0;
            vblnk_prev_q <= 1'b0;
            hit_q        <= 1'b0;
            invuln_q     <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            hit_q        <= 1'b0;
            if (!game_on) begin
                // Leaving the game drops all state except the hit count, which is kept for readout.
                state_q   <= IDLE;
                flag_q    <= 1'b0;
                frm_cnt_q <= '0;
                invuln_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= ARMED;
                        hit_cnt_q <= '0;
                        flag_q    <= 1'b0;
                        invuln_q  <= 1'b0;
                    end
                    ARMED: begin
                        if (frame_end) begin
                            flag_q <= 1'b0;
                            if (flag_q || sample) begin
                                hit_q     <= 1'b1;
                                invuln_q  <= 1'b1;
                                frm_cnt_q <= INV_LD;
                                state_q   <= COOLDOWN;
                                if (hit_cnt_q != CNT_MAX)
                                    hit_cnt_q <= hit_cnt_q + 1'b1;
                            end
                        end else if (sample) begin
                            flag_q <= 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        // Collisions are ignored while the counter runs; this frame end is the last one when the counter is 1.
                        if (frame_end) begin
                            if (frm_cnt_q <= 8'd1) begin
                                frm_cnt_q <= '0;
                                state_q   <= ARMED;
                                invuln_q  <= 1'b0;
                            end else begin
                                frm_cnt_q <= frm_cnt_q - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        flag_q   <= 1'b0;
                        invuln_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign player_hit = hit_q;
    assign invuln     = invuln_q;
    assign hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_hit_detector.sv
// Self-checking bench for hit_detector: a vector table for the pass-through path,
// directed frame sequences for the hit and cooldown corner cases, and random
// traffic checked against a frame-level reference model.
module tb_hit_detector;

    localparam int          PS   = 20;
    localparam logic [11:0] RED  = 12'hf00;
    localparam logic [11:0] GRN  = 12'h0f0;
    localparam int          INV  = 3;
    localparam int          HW   = 3;
    localparam int          HMAX = (1 << HW) - 1;

    logic          pclk = 1'b0;
    logic          rst;
    logic [11:0]   hcount_in, vcount_in, rgb_in, player_x, player_y;
    logic          hsync_in, vsync_in, hblnk_in, vblnk_in, game_on;
    logic [11:0]   hcount_out, vcount_out, rgb_out;
    logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic          player_hit, invuln;
    logic [HW-1:0] hit_count;

    always #5 pclk = ~pclk;

    hit_detector #(
        .PLAYER_SIZE(PS), .OBSTACLE_COLOR(RED), .INVULN_FRAMES(INV), .HIT_CNT_W(HW)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .player_x(player_x), .player_y(player_y), .game_on(game_on),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .player_hit(player_hit), .invuln(invuln), .hit_count(hit_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, at frame granularity: whether a game is running, whether the
    // player is immune and how many frame ends have passed since the last hit.
    bit          m_active, m_immune, m_flag, m_prev_vb;
    int          m_since, m_hits;
    logic [11:0] e_hc, e_vc, e_rgb;
    logic [3:0]  e_ctl;
    bit          e_hit, e_inv;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model();
        bit fe, coll, inbox;
        if (rst) begin
            e_hc = 0; e_vc = 0; e_rgb = 0; e_ctl = 0; e_hit = 0; e_inv = 0;
            m_active = 0; m_immune = 0; m_flag = 0; m_prev_vb = 0; m_since = 0; m_hits = 0;
        end else begin
            e_hc = hcount_in; e_vc = vcount_in; e_rgb = rgb_in;
            e_ctl = {hsync_in, vsync_in, hblnk_in, vblnk_in};
            fe = vblnk_in && !m_prev_vb;
            m_prev_vb = vblnk_in;
            e_hit = 0;
            inbox = (int'(hcount_in) >= int'(player_x)) && (int'(hcount_in) < int'(player_x) + PS) &&
                    (int'(vcount_in) >= int'(player_y)) && (int'(vcount_in) < int'(player_y) + PS);
            if (!game_on) begin
                m_active = 0; m_immune = 0; m_flag = 0;
            end else if (!m_active) begin
                m_active = 1; m_immune = 0; m_flag = 0; m_hits = 0;
            end else if (!m_immune) begin
                coll = !vblnk_in && !hblnk_in && inbox && (rgb_in == RED);
                if (fe) begin
                    if (m_flag || coll) begin
                        e_hit = 1; m_immune = 1; m_since = 0;
                        if (m_hits < HMAX) m_hits++;
                    end
                    m_flag = 0;
                end else if (coll) begin
                    m_flag = 1;
                end
            end else if (fe) begin
                m_since++;
                if (m_since >= INV) m_immune = 0;
            end
            e_inv = m_immune;
        end
    endtask

    // One clock: the model consumes the inputs applied for this edge, and every output is checked 1 ns later.
    task automatic step();
        @(posedge pclk);
        model();
        #1;
        chk("hcount_out", hcount_out, e_hc);
        chk("vcount_out", vcount_out, e_vc);
        chk("rgb_out", rgb_out, e_rgb);
        chk("timing_out", {hsync_out, vsync_out, hblnk_out, vblnk_out}, e_ctl);
        chk("player_hit", player_hit, e_hit);
        chk("invuln", invuln, e_inv);
        chk("hit_count", hit_count, m_hits);
    endtask

    task automatic drive(input int h, input int v, input bit hb, input bit vb, input logic [11:0] c);
        hcount_in = 12'(h); vcount_in = 12'(v); hblnk_in = hb; vblnk_in = vb;
        hsync_in = hb; vsync_in = vb; rgb_in = c;
        step();
    endtask

    // Rising vblnk edge followed by the rest of the blanking; reports the pulse seen right after the edge.
    task automatic fend(output bit hit, output bit inv);
        drive(0, 0, 1, 1, 12'h000);
        hit = player_hit; inv = invuln;
        drive(0, 0, 1, 1, 12'h000);
        drive(0, 0, 1, 0, 12'h000);
    endtask

    task automatic restart();
        game_on = 0; drive(0, 0, 1, 0, 12'h000);
        game_on = 1; drive(0, 0, 1, 0, 12'h000);
    endtask

    typedef struct {
        logic [11:0] h, v, rgb;
        logic [3:0]  ctl;
        logic [11:0] eh, ev, ergb;
        logic [3:0]  ectl;
    } vec_t;

    vec_t vecs[5];
    bit   h, iv;
    int   fr;

    initial begin
        vecs[0] = '{12'd100,  12'd0,    12'h123, 4'b0000, 12'd100,  12'd0,    12'h123, 4'b0000};
        vecs[1] = '{12'd4095, 12'd4095, 12'hfff, 4'b1111, 12'd4095, 12'd4095, 12'hfff, 4'b1111};
        vecs[2] = '{12'd305,  12'd410,  12'hf00, 4'b0101, 12'd305,  12'd410,  12'hf00, 4'b0101};
        vecs[3] = '{12'd0,    12'd2047, 12'h0f0, 4'b1010, 12'd0,    12'd2047, 12'h0f0, 4'b1010};
        vecs[4] = '{12'd1,    12'd1,    12'h000, 4'b0000, 12'd1,    12'd1,    12'h000, 4'b0000};

        // Reset with random inputs: every output must be zero.
        rst = 1; game_on = 0; player_x = 12'd300; player_y = 12'd400;
        for (int i = 0; i < 5; i++) begin
            game_on = 1'($urandom);
            drive(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  1'($urandom), 1'($urandom), 12'($urandom));
            chk("reset_outputs_zero",
                {hcount_out, vcount_out, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 player_hit, invuln, hit_count}, 0);
        end
        rst = 0; game_on = 0;

        // Pass-through table.
        for (int i = 0; i < 5; i++) begin
            hcount_in = vecs[i].h; vcount_in = vecs[i].v; rgb_in = vecs[i].rgb;
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = vecs[i].ctl;
            step();
            chk("tbl_hcount", hcount_out, vecs[i].eh);
            chk("tbl_vcount", vcount_out, vecs[i].ev);
            chk("tbl_rgb", rgb_out, vecs[i].ergb);
            chk("tbl_timing", {hsync_out, vsync_out, hblnk_out, vblnk_out}, vecs[i].ectl);
        end
        drive(0, 0, 1, 0, 12'h000);

        // A single red pixel inside the box gives one pulse at frame end.
        restart();
        drive(305, 410, 0, 0, RED);
        drive(306, 410, 0, 0, GRN);
        fend(h, iv);
        chk("hit_pulse_frame1", h, 1);
        chk("hit_count_after_hit", hit_count, 1);
        chk("invuln_after_hit", iv, 1);

        // Boundary: a red pixel one past the right edge and a green pixel inside the box do not hit.
        restart();
        for (int f = 0; f < 3; f++) begin
            drive(320, 410, 0, 0, RED);
            drive(310, 410, 0, 0, GRN);
            drive(300, 419, 0, 0, GRN);
            fend(h, iv);
            chk("no_hit_edge", h, 0);
        end
        chk("no_hit_count", hit_count, 0);

        // Collision in every frame with INV=3: pulses at frame ends 1 and 5 only.
        restart();
        for (int f = 1; f <= 6; f++) begin
            drive(305, 410, 0, 0, RED);
            fend(h, iv);
            chk("cooldown_pulse", h, (f == 1 || f == 5));
            chk("cooldown_invuln", iv, (f != 4));
        end

        // Ten separate hits saturate the 3-bit counter at 7.
        restart();
        for (int f = 0; f < 40; f++) begin
            drive(310, 415, 0, 0, RED);
            fend(h, iv);
        end
        chk("hit_count_saturates", hit_count, HMAX);

        // game_on dropped in cooldown: back to IDLE, count kept; re-entry clears it and re-arms.
        restart();
        drive(305, 410, 0, 0, RED);
        fend(h, iv);
        fend(h, iv);
        game_on = 0; drive(0, 0, 1, 0, 12'h000);
        chk("idle_invuln_low", invuln, 0);
        chk("idle_count_held", hit_count, 1);
        game_on = 1; drive(0, 0, 1, 0, 12'h000);
        chk("rearm_count_clear", hit_count, 0);
        drive(305, 410, 0, 0, RED);
        fend(h, iv);
        chk("rearm_immediate_hit", h, 1);
        chk("rearm_hit_count", hit_count, 1);

        // Reset in mid-frame with the flag set: no pulse afterwards.
        restart();
        drive(305, 410, 0, 0, RED);
        rst = 1; drive(306, 410, 0, 0, GRN);
        rst = 0;
        fend(h, iv);
        chk("reset_drops_flag", h, 0);
        chk("reset_count_zero", hit_count, 0);

        // Random traffic against the model, including boxes at the right border (no wrap).
        fr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0: begin player_x = 12'd300; player_y = 12'd400; end
                    1: begin player_x = 12'd4085; player_y = 12'd4080; end
                    default: begin player_x = 12'($urandom_range(0, 4095)); player_y = 12'($urandom_range(0, 4095)); end
                endcase
                fr++;
            end
            rst = ($urandom_range(0, 499) == 0);
            game_on = ($urandom_range(0, 99) != 0);
            drive((int'(player_x) + int'($urandom_range(0, 25)) - 3) & 12'hfff,
                  (int'(player_y) + int'($urandom_range(0, 25)) - 3) & 12'hfff,
                  ($urandom_range(0, 7) == 0), ((c % 40) >= 36),
                  ($urandom_range(0, 1) == 1) ? RED : 12'($urandom));
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
